// File: rtl/ysyx_23060208_clint.sv
// ysyx_23060208_clint
//
// Core-local timer slave. A free-running 64-bit mtime counter is exposed as a
// read-only AXI4-Lite slave: BASE_ADDR returns mtime[31:0], BASE_ADDR+4 returns
// mtime[63:32]. A low-word read snapshots the high word into a shadow register,
// so a low-then-high read pair gives a coherent 64-bit value across a carry.
// Every other address answers SLVERR with zero data.
//
// Parameters
//   DATA_WIDTH  read data width
//   ADDR_WIDTH  address width
//   BASE_ADDR   address of mtime[31:0]
//   TICK_DIV    mtime increments once every TICK_DIV clk cycles (>= 1)
//   RESP_DELAY  extra wait cycles between AR handshake and rvalid (0..15)
//
// Ports
//   clk              clock
//   rst              synchronous, active-high reset
//   clint_araddr_i   read address
//   clint_arvalid_i  read address valid
//   clint_arready_o  read address ready (high only in IDLE, low during reset)
//   clint_rdata_o    registered read data
//   clint_rresp_o    registered response, 2'b00 OKAY / 2'b10 SLVERR
//   clint_rvalid_o   read data valid (high only in RESP, low during reset)
//   clint_rready_i   read data ready

module ysyx_23060208_clint #(
    parameter int unsigned            DATA_WIDTH = 32,
    parameter int unsigned            ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR  = ADDR_WIDTH'(32'ha000_0048),
    parameter int unsigned            TICK_DIV   = 1,
    parameter int unsigned            RESP_DELAY = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] clint_araddr_i,
    input  logic                  clint_arvalid_i,
    output logic                  clint_arready_o,
    output logic [DATA_WIDTH-1:0] clint_rdata_o,
    output logic [1:0]            clint_rresp_o,
    output logic                  clint_rvalid_o,
    input  logic                  clint_rready_i
);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [ADDR_WIDTH-1:0] HI_ADDR = BASE_ADDR + ADDR_WIDTH'(4);

    // Prescaler width; a 1-bit register is kept even when TICK_DIV==1.
    localparam int unsigned         PDIV_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PDIV_W-1:0]   PDIV_MAX = PDIV_W'(TICK_DIV - 1);

    // Delay counter reload; only meaningful when RESP_DELAY > 0.
    localparam logic [3:0] DLY_INIT = (RESP_DELAY > 0) ? 4'(RESP_DELAY - 1) : 4'd0;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } state_e;

    // ------------------------------------------------------------------
    // Counter
    // ------------------------------------------------------------------
    logic [63:0]       mtime_q, mtime_d;
    logic [PDIV_W-1:0] pdiv_q, pdiv_d;
    logic              tick;

    assign tick = (pdiv_q == PDIV_MAX);

    always_comb begin
        pdiv_d  = tick ? '0 : pdiv_q + PDIV_W'(1);
        // Wraps silently from all-ones to zero.
        mtime_d = tick ? mtime_q + 64'd1 : mtime_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mtime_q <= '0;
            pdiv_q  <= '0;
        end else begin
            mtime_q <= mtime_d;
            pdiv_q  <= pdiv_d;
        end
    end

    // ------------------------------------------------------------------
    // Read channel FSM, shadow register and registered response
    // ------------------------------------------------------------------
    state_e                  state_q, state_d;
    logic [3:0]              dly_cnt_q, dly_cnt_d;
    logic [31:0]             hi_shadow_q, hi_shadow_d;
    logic                    shadow_vld_q, shadow_vld_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic [1:0]              rresp_q, rresp_d;
    logic                    ar_hs;
    logic                    r_hs;

    // Handshake strobes decode from state so reset gating covers them too.
    assign clint_arready_o = (state_q == StIdle) && !rst;
    assign clint_rvalid_o  = (state_q == StResp) && !rst;
    assign clint_rdata_o   = rdata_q;
    assign clint_rresp_o   = rresp_q;

    assign ar_hs = clint_arvalid_i && clint_arready_o;
    assign r_hs  = clint_rvalid_o && clint_rready_i;

    always_comb begin
        state_d      = state_q;
        dly_cnt_d    = dly_cnt_q;
        hi_shadow_d  = hi_shadow_q;
        shadow_vld_d = shadow_vld_q;
        rdata_d      = rdata_q;
        rresp_d      = rresp_q;

        unique case (state_q)
            StIdle: begin
                if (ar_hs) begin
                    // Data is sampled from the pre-increment mtime of the
                    // handshake cycle.
                    if (clint_araddr_i == BASE_ADDR) begin
                        rdata_d      = DATA_WIDTH'(mtime_q[31:0]);
                        rresp_d      = RESP_OKAY;
                        hi_shadow_d  = mtime_q[63:32];
                        shadow_vld_d = 1'b1;
                    end else if (clint_araddr_i == HI_ADDR) begin
                        rdata_d      = shadow_vld_q ? DATA_WIDTH'(hi_shadow_q)
                                                    : DATA_WIDTH'(mtime_q[63:32]);
                        rresp_d      = RESP_OKAY;
                        shadow_vld_d = 1'b0;
                    end else begin
                        // Unmapped: shadow state deliberately left alone.
                        rdata_d = '0;
                        rresp_d = RESP_SLVERR;
                    end
                    state_d   = (RESP_DELAY > 0) ? StWait : StResp;
                    dly_cnt_d = DLY_INIT;
                end
            end
            StWait: begin
                if (dly_cnt_q == 4'd0) begin
                    state_d = StResp;
                end else begin
                    dly_cnt_d = dly_cnt_q - 4'd1;
                end
            end
            StResp: begin
                if (r_hs) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            dly_cnt_q    <= '0;
            hi_shadow_q  <= '0;
            shadow_vld_q <= 1'b0;
            rdata_q      <= '0;
            rresp_q      <= RESP_OKAY;
        end else begin
            state_q      <= state_d;
            dly_cnt_q    <= dly_cnt_d;
            hi_shadow_q  <= hi_shadow_d;
            shadow_vld_q <= shadow_vld_d;
            rdata_q      <= rdata_d;
            rresp_q      <= rresp_d;
        end
    end

endmodule
